// File: rtl/dma_addr_gen_pkg.sv
// Shared encodings for the DMA address generator: instruction codes, transfer
// modes and control-register layout.
package dma_addr_gen_pkg;

    localparam int CR_W    = 3;
    localparam int DIR_BIT = 2;

    typedef enum logic [2:0] {
        INSTR_NOP     = 3'd0,
        INSTR_WR_CR   = 3'd1,
        INSTR_RD_CR   = 3'd2,
        INSTR_RD_WC   = 3'd3,
        INSTR_RD_AC   = 3'd4,
        INSTR_REINIT  = 3'd5,
        INSTR_LD_ADDR = 3'd6,
        INSTR_LD_WC   = 3'd7
    } instr_e;

    typedef enum logic [1:0] {
        MODE_WC_STOP   = 2'd0,
        MODE_WC_RELOAD = 2'd1,
        MODE_ADDR_CMP  = 2'd2,
        MODE_FREE      = 2'd3
    } mode_e;

endpackage

// File: rtl/dma_counter.sv
// Loadable WIDTH-bit up/down counter. hit_o flags that the value the counter
// would take on a step equals cmp_i, so callers can act on the stepping edge.
module dma_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] cmp_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             hit_o
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d, stepped;

    always_comb begin
        stepped = down_i ? (cnt_q - ONE) : (cnt_q + ONE);
        cnt_d   = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (step_i) begin
            cnt_d = stepped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (stepped == cmp_i);

endmodule

// File: rtl/dma_addr_gen.sv
// DMA address generator: instruction decode, transfer-termination modes, done
// tracking and readback mux around an address counter and a word counter.
module dma_addr_gen
    import dma_addr_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic [2:0]       instr,
    input  logic [WIDTH-1:0] bus_data_in,
    input  logic             ena,
    input  logic             aci,
    output logic [WIDTH-1:0] address_out,
    output logic [WIDTH-1:0] data_out,
    output logic             data_oe,
    output logic             done,
    output logic             aco
);
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] wreg_q, wreg_d;
    logic [CR_W-1:0]  cr_q, cr_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] acnt, wcnt;
    logic [WIDTH-1:0] a_load_val, w_load_val;
    logic             a_hit, w_hit;
    logic             a_load, w_load;
    logic             dir_down, halt, step, reload;
    instr_e           op;
    mode_e            mode;

    always_comb begin
        op       = instr_e'(instr);
        mode     = mode_e'(cr_q[1:0]);
        dir_down = cr_q[DIR_BIT];
        halt     = done_q & ((mode == MODE_WC_STOP) | (mode == MODE_ADDR_CMP));
        step     = ena & aci & ~halt &
                   (op inside {INSTR_NOP, INSTR_RD_CR, INSTR_RD_WC, INSTR_RD_AC});
        // w_hit means the word counter is about to step from 1 to 0
        reload   = step & (mode == MODE_WC_RELOAD) & w_hit;

        a_load     = reload | (op == INSTR_REINIT) | (op == INSTR_LD_ADDR);
        a_load_val = (op == INSTR_LD_ADDR) ? bus_data_in : areg_q;
        w_load     = reload | (op == INSTR_REINIT) | (op == INSTR_LD_WC);
        w_load_val = (op == INSTR_LD_WC) ? bus_data_in : wreg_q;

        areg_d = (op == INSTR_LD_ADDR) ? bus_data_in : areg_q;
        wreg_d = (op == INSTR_LD_WC) ? bus_data_in : wreg_q;
        cr_d   = (op == INSTR_WR_CR) ? bus_data_in[CR_W-1:0] : cr_q;

        done_d = done_q;
        if (op inside {INSTR_WR_CR, INSTR_REINIT, INSTR_LD_ADDR, INSTR_LD_WC}) begin
            done_d = 1'b0;
        end else begin
            case (mode)
                MODE_WC_STOP:   if (step & w_hit) done_d = 1'b1;
                MODE_WC_RELOAD: done_d = reload;
                MODE_ADDR_CMP:  if (step & a_hit) done_d = 1'b1;
                default:        done_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            areg_q <= '0;
            wreg_q <= '0;
            cr_q   <= '0;
            done_q <= 1'b0;
        end else begin
            areg_q <= areg_d;
            wreg_q <= wreg_d;
            cr_q   <= cr_d;
            done_q <= done_d;
        end
    end

    dma_counter #(.WIDTH(WIDTH)) u_addr_cnt (
        .clk        (clk),
        .rst        (res),
        .load_i     (a_load),
        .load_val_i (a_load_val),
        .step_i     (step),
        .down_i     (dir_down),
        .cmp_i      (wreg_q),
        .cnt_o      (acnt),
        .hit_o      (a_hit)
    );

    dma_counter #(.WIDTH(WIDTH)) u_word_cnt (
        .clk        (clk),
        .rst        (res),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .step_i     (step),
        .down_i     (1'b1),
        .cmp_i      ('0),
        .cnt_o      (wcnt),
        .hit_o      (w_hit)
    );

    always_comb begin
        data_out = '0;
        data_oe  = 1'b0;
        case (op)
            INSTR_RD_CR: begin data_out = WIDTH'(cr_q); data_oe = 1'b1; end
            INSTR_RD_WC: begin data_out = wcnt;         data_oe = 1'b1; end
            INSTR_RD_AC: begin data_out = acnt;         data_oe = 1'b1; end
            default: ;
        endcase
    end

    assign address_out = acnt;
    assign done        = done_q;
    assign aco         = ena & aci & ~halt & (dir_down ? (acnt == '0) : (&acnt));

endmodule

// File: tb/tb_dma_addr_gen.sv
// Scoreboard bench for dma_addr_gen: driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares every cycle.
module tb_dma_addr_gen;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [2:0] instr = 3'd0;
    logic [7:0] bus_data_in = 8'h00;
    logic       ena = 1'b0;
    logic       aci = 1'b0;
    logic [7:0] address_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic       done;
    logic       aco;

    dma_addr_gen #(.WIDTH(8)) dut (
        .clk         (clk),
        .res         (res),
        .instr       (instr),
        .bus_data_in (bus_data_in),
        .ena         (ena),
        .aci         (aci),
        .address_out (address_out),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .done        (done),
        .aco         (aco)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       oe;
        logic       dn;
        logic       co;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // reference state
    logic [7:0] m_areg = 0, m_acnt = 0, m_wreg = 0, m_wcnt = 0;
    logic [2:0] m_cr = 0;
    logic       m_done = 0;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
        end
    endfunction

    // Computes this cycle's visible outputs, then advances the model across the edge.
    task automatic model(output exp_t x);
        logic [1:0] mode;
        logic       down, halt, stepping;
        if (res) begin
            m_areg = 0; m_acnt = 0; m_wreg = 0; m_wcnt = 0; m_cr = 0; m_done = 0;
        end
        mode     = m_cr[1:0];
        down     = m_cr[2];
        halt     = m_done && (mode == 2'd0 || mode == 2'd2);
        stepping = ena && aci && !halt;
        x.addr = m_acnt;
        x.dn   = m_done;
        x.co   = stepping && (down ? (m_acnt == 8'h00) : (m_acnt == 8'hFF));
        x.oe   = 1'b0;
        x.data = 8'h00;
        case (instr)
            3'd2: begin x.oe = 1'b1; x.data = {5'b0, m_cr}; end
            3'd3: begin x.oe = 1'b1; x.data = m_wcnt; end
            3'd4: begin x.oe = 1'b1; x.data = m_acnt; end
            default: ;
        endcase
        if (res) return;
        case (instr)
            3'd1: begin m_cr = bus_data_in[2:0]; m_done = 0; end
            3'd5: begin m_acnt = m_areg; m_wcnt = m_wreg; m_done = 0; end
            3'd6: begin m_areg = bus_data_in; m_acnt = bus_data_in; m_done = 0; end
            3'd7: begin m_wreg = bus_data_in; m_wcnt = bus_data_in; m_done = 0; end
            default: begin
                if (mode == 2'd1) m_done = 0;
                if (stepping) begin
                    if (mode == 2'd1 && m_wcnt == 8'd1) begin
                        m_acnt = m_areg;
                        m_wcnt = m_wreg;
                        m_done = 1;
                    end else begin
                        m_acnt = down ? m_acnt - 8'd1 : m_acnt + 8'd1;
                        if (mode == 2'd0 && m_wcnt == 8'd1) m_done = 1;
                        m_wcnt = m_wcnt - 8'd1;
                        if (mode == 2'd2 && m_acnt == m_wreg) m_done = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic cyc(input logic [2:0] ins, input logic [7:0] bus,
                       input logic e, input logic a, input logic r);
        exp_t x;
        @(posedge clk);
        #1;
        instr = ins; bus_data_in = bus; ena = e; aci = a; res = r;
        model(x);
        exp_q.push_back(x);
    endtask

    task automatic steps(input int n, input logic [2:0] ins);
        for (int i = 0; i < n; i++) cyc(ins, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("address_out", address_out, mon_e.addr);
            chk("data_out", data_out, mon_e.data);
            chk("data_oe", {7'b0, data_oe}, {7'b0, mon_e.oe});
            chk("done", {7'b0, done}, {7'b0, mon_e.dn});
            chk("aco", {7'b0, aco}, {7'b0, mon_e.co});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] ins;
        logic [7:0] bus;
        int         r;

        // reset and idle after release
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // mode 0, increment
        cyc(3'd6, 8'h10, 1'b0, 1'b0, 1'b0);
        cyc(3'd7, 8'h03, 1'b0, 1'b0, 1'b0);
        cyc(3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        steps(5, 3'd0);
        cyc(3'd3, 8'h00, 1'b0, 1'b0, 1'b0);

        // mode 1, decrement, repeated reload pulses
        cyc(3'd1, 8'h05, 1'b0, 1'b0, 1'b0);
        cyc(3'd6, 8'h05, 1'b0, 1'b0, 1'b0);
        cyc(3'd7, 8'h02, 1'b0, 1'b0, 1'b0);
        steps(6, 3'd0);

        // mode 2, increment across wrap
        cyc(3'd6, 8'hFE, 1'b0, 1'b0, 1'b0);
        cyc(3'd7, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc(3'd1, 8'h02, 1'b0, 1'b0, 1'b0);
        steps(5, 3'd0);

        // priority and gating
        cyc(3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(3'd6, 8'h40, 1'b1, 1'b1, 1'b0);
        cyc(3'd4, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc(3'd4, 8'h00, 1'b0, 1'b0, 1'b0);

        // reinit in free mode
        cyc(3'd1, 8'h03, 1'b0, 1'b0, 1'b0);
        cyc(3'd6, 8'h20, 1'b0, 1'b0, 1'b0);
        cyc(3'd7, 8'h08, 1'b0, 1'b0, 1'b0);
        steps(2, 3'd0);
        cyc(3'd5, 8'h00, 1'b1, 1'b1, 1'b0);
        cyc(3'd4, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(3'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(3'd2, 8'h00, 1'b0, 1'b0, 1'b0);

        // reset mid-transfer
        steps(3, 3'd0);
        cyc(3'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 15);
            if (r < 10) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: ins = 3'd0;
                    3:       ins = 3'd2;
                    4:       ins = 3'd3;
                    default: ins = 3'd4;
                endcase
            end else begin
                ins = 3'($urandom_range(1, 7));
            end
            if (ins == 3'd7 && $urandom_range(0, 1) == 1) bus = 8'($urandom_range(0, 5));
            else if (ins == 3'd6 && $urandom_range(0, 2) == 0) bus = 8'($urandom_range(250, 255));
            else bus = 8'($urandom);
            cyc(ins, bus, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 79) == 0);
        end
        cyc(3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
